// File: rtl/twos_complement_iter_if.sv
// Handshake bundle for the iterative two's-complement operand conditioner.
// The out_ovf wire exists only when TWC_OVF_FLAG_EN is defined.
interface twos_complement_iter_if #(
    parameter int WIDTH = 11
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
`ifdef TWC_OVF_FLAG_EN
    logic             out_ovf;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_ovf
    );
    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_ovf
    );
`else
    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_zero
    );
    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_zero
    );
`endif
endinterface

// File: rtl/twos_complement_iter.sv
// Multi-cycle operand conditioner: pass / ones' / twos' / abs, resolving CHUNK bits per cycle.
// Optional overflow flag (most-negative operand negated) enabled with TWC_OVF_FLAG_EN.
//
// state | meaning
// IDLE  | ready for an operand; handshake latches operand and resolves inv/cin
// BUSY  | one chunk per cycle, LSB first, ripple carry held between cycles
// DONE  | result valid and held until out_ready
module twos_complement_iter #(
    parameter int WIDTH = 11,
    parameter int CHUNK = 4
) (
    input  logic clk,
    input  logic reset,
    twos_complement_iter_if.slave bus
);
    localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_nxt;
    logic             inv;
    logic             carry;
    logic             zero_q;
    logic [IDXW-1:0]  idx;
    logic             last;
    logic             mode_inv;
    logic             mode_cin;
    int               shamt;
    logic [CHUNK-1:0] op_chunk;
    logic [CHUNK:0]   sum;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] placed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = ~reset;
                if (bus.in_valid) state_nxt = BUSY;
            end
            BUSY: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The partial top chunk sees zero-filled operand bits; the mask drops them on write-back.
    always_comb begin
        mode_inv = (bus.in_mode == 2'b01) | (bus.in_mode == 2'b10) |
                   ((bus.in_mode == 2'b11) & bus.in_data[WIDTH-1]);
        mode_cin = (bus.in_mode == 2'b10) |
                   ((bus.in_mode == 2'b11) & bus.in_data[WIDTH-1]);
        last       = (idx == LAST_IDX);
        shamt      = int'(idx) * CHUNK;
        op_chunk   = CHUNK'(operand >> shamt);
        sum        = {1'b0, op_chunk ^ {CHUNK{inv}}} + {{CHUNK{1'b0}}, carry};
        mask       = WIDTH'({CHUNK{1'b1}}) << shamt;
        placed     = WIDTH'(sum[CHUNK-1:0]) << shamt;
        result_nxt = (result & ~mask) | (placed & mask);
    end

`ifdef TWC_OVF_FLAG_EN
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    logic neg;
    logic ovf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            neg   <= 1'b0;
            ovf_q <= 1'b0;
        end else if (state == IDLE && bus.in_valid) begin
            neg <= mode_cin;
        end else if (state == BUSY && last) begin
            ovf_q <= neg & (operand == MOST_NEG);
        end
    end

    assign bus.out_ovf = ovf_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            operand <= '0;
            result  <= '0;
            inv     <= 1'b0;
            carry   <= 1'b0;
            idx     <= '0;
            zero_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        operand <= bus.in_data;
                        inv     <= mode_inv;
                        carry   <= mode_cin;
                        idx     <= '0;
                    end
                end
                BUSY: begin
                    result <= result_nxt;
                    if (last) begin
                        carry  <= 1'b0;
                        idx    <= '0;
                        zero_q <= (result_nxt == '0);
                    end else begin
                        carry <= sum[CHUNK];
                        idx   <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out_data = result;
    assign bus.out_zero = zero_q;

endmodule

// File: tb/tb_twos_complement_iter.sv
// Directed bench for twos_complement_iter: 11/4 and 24/5 instances, scoreboard queues per instance.
// Overflow-flag checks compile in when TWC_OVF_FLAG_EN is defined.
module tb_twos_complement_iter;

    typedef struct {
        logic [31:0] data;
        logic        zero;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   passed = 0;
    int   total  = 0;
    exp_t sb11[$];
    exp_t sb24[$];

    always #5 clk = ~clk;

    twos_complement_iter_if #(.WIDTH(11)) b11 ();
    twos_complement_iter_if #(.WIDTH(24)) b24 ();

    twos_complement_iter #(.WIDTH(11), .CHUNK(4)) dut11 (.clk(clk), .reset(reset), .bus(b11));
    twos_complement_iter #(.WIDTH(24), .CHUNK(5)) dut24 (.clk(clk), .reset(reset), .bus(b24));

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] mode, input logic [31:0] d, input int w);
        exp_t        e;
        logic [31:0] m;
        logic [31:0] r;
        logic        neg;
        m   = (32'h1 << w) - 32'h1;
        neg = d[w-1];
        case (mode)
            2'b00:   r = d;
            2'b01:   r = ~d;
            2'b10:   r = -d;
            default: r = neg ? -d : d;
        endcase
        e.data = r & m;
        e.zero = (e.data == 32'h0);
        e.ovf  = ((mode == 2'b10) || (mode == 2'b11 && neg)) && (d == (32'h1 << (w - 1)));
        return e;
    endfunction

    task automatic drive11(input logic [1:0] mode, input logic [10:0] d);
        int n;
        @(negedge clk);
        b11.in_mode  = mode;
        b11.in_data  = d;
        b11.in_valid = 1'b1;
        sb11.push_back(model(mode, 32'(d), 11));
        n = 0;
        while (!b11.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept11", 32'(b11.in_ready), 32'h1);
        @(posedge clk);
        #1 b11.in_valid = 1'b0;
    endtask

    task automatic wait_valid11(input bit chk_lat);
        int lat;
        lat = 0;
        @(negedge clk);
        while (!b11.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("valid11", 32'(b11.out_valid), 32'h1);
        if (chk_lat) check("latency11", 32'(lat), 32'd3);
    endtask

    task automatic finish11(input string tag);
        exp_t e;
        e = sb11.pop_front();
        check({tag, "_data"}, 32'(b11.out_data), e.data);
        check({tag, "_zero"}, 32'(b11.out_zero), 32'(e.zero));
`ifdef TWC_OVF_FLAG_EN
        check({tag, "_ovf"}, 32'(b11.out_ovf), 32'(e.ovf));
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic op11(input string tag, input logic [1:0] mode, input logic [10:0] d);
        drive11(mode, d);
        wait_valid11(1'b1);
        finish11(tag);
    endtask

    task automatic op24(input string tag, input logic [1:0] mode, input logic [23:0] d);
        int   n;
        int   lat;
        exp_t e;
        @(negedge clk);
        b24.in_mode  = mode;
        b24.in_data  = d;
        b24.in_valid = 1'b1;
        sb24.push_back(model(mode, 32'(d), 24));
        n = 0;
        while (!b24.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept24", 32'(b24.in_ready), 32'h1);
        @(posedge clk);
        #1 b24.in_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!b24.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("valid24", 32'(b24.out_valid), 32'h1);
        check("latency24", 32'(lat), 32'd5);
        e = sb24.pop_front();
        check({tag, "_data"}, 32'(b24.out_data), e.data);
        check({tag, "_zero"}, 32'(b24.out_zero), 32'(e.zero));
`ifdef TWC_OVF_FLAG_EN
        check({tag, "_ovf"}, 32'(b24.out_ovf), 32'(e.ovf));
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [10:0] held;
        int          seen;

        reset        = 1'b1;
        b11.in_valid = 1'b0;
        b11.in_data  = '0;
        b11.in_mode  = 2'b00;
        b11.out_ready = 1'b1;
        b24.in_valid = 1'b0;
        b24.in_data  = '0;
        b24.in_mode  = 2'b00;
        b24.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(b11.out_valid), 32'h0);
        check("rst_out_data", 32'(b11.out_data), 32'h0);
        check("rst_out_zero", 32'(b11.out_zero), 32'h0);
        check("rst_in_ready", 32'(b11.in_ready), 32'h0);
`ifdef TWC_OVF_FLAG_EN
        check("rst_out_ovf", 32'(b11.out_ovf), 32'h0);
`endif
        reset = 1'b0;
        #1 check("post_rst_in_ready", 32'(b11.in_ready), 32'h1);

        op11("neg_one", 2'b10, 11'h001);
        op11("neg_zero", 2'b10, 11'h000);
        op11("ones", 2'b01, 11'h2A5);
        op11("abs_neg5", 2'b11, 11'h7FB);
        op11("abs_pos5", 2'b11, 11'h005);
        op11("abs_mostneg", 2'b11, 11'h400);
        op11("ones_mostneg", 2'b01, 11'h400);
        op11("pass", 2'b00, 11'h123);
        op11("neg_mostneg", 2'b10, 11'h400);

        // output stall: result must hold while a second operand is offered
        b11.out_ready = 1'b0;
        drive11(2'b01, 11'h0F0);
        wait_valid11(1'b1);
        held = b11.out_data;
        b11.in_mode  = 2'b10;
        b11.in_data  = 11'h00A;
        b11.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(b11.out_valid), 32'h1);
            check("stall_data", 32'(b11.out_data), 32'(held));
            check("stall_in_ready", 32'(b11.in_ready), 32'h0);
        end
        b11.out_ready = 1'b1;
        sb11.push_back(model(2'b10, 32'h00A, 11));
        finish11("stall_first");
        check("after_out_hs_valid", 32'(b11.out_valid), 32'h0);
        check("after_out_hs_ready", 32'(b11.in_ready), 32'h1);
        @(posedge clk);
        #1 b11.in_valid = 1'b0;
        check("second_taken", 32'(b11.in_ready), 32'h0);
        wait_valid11(1'b1);
        finish11("stall_second");

        // reset during BUSY with carry pending (neg of zero keeps carry set)
        @(negedge clk);
        b11.in_mode  = 2'b10;
        b11.in_data  = 11'h000;
        b11.in_valid = 1'b1;
        @(posedge clk);
        #1 b11.in_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort_out_valid", 32'(b11.out_valid), 32'h0);
        check("abort_out_data", 32'(b11.out_data), 32'h0);
        check("abort_out_zero", 32'(b11.out_zero), 32'h0);
        check("abort_in_ready", 32'(b11.in_ready), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1 check("abort_release_ready", 32'(b11.in_ready), 32'h1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (b11.out_valid) seen++;
        end
        check("abort_no_valid", 32'(seen), 32'h0);
        op11("after_abort", 2'b01, 11'h2A5);
        op11("after_abort_neg", 2'b10, 11'h001);

        op24("w24_neg_one", 2'b10, 24'h000001);
        op24("w24_abs_mostneg", 2'b11, 24'h800000);
        op24("w24_abs_neg", 2'b11, 24'hF0F0F1);
        op24("w24_ones", 2'b01, 24'h0ABCDE);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
